// File: rtl/alu_mdu_controller.sv
// ALU operation decoder plus an optional iterative multiply/divide unit.
// Decode is purely combinational; the MDU spends exactly XLEN radix-2 steps per operation.
module alu_mdu_controller #(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [1:0]      ALUOp,
    input  logic            Itype,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic [3:0]      Operation,
    output logic            illegal,
    output logic            is_mdu,
    output logic            stall,
    output logic            mdu_done,
    output logic [XLEN-1:0] mdu_result
);

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_EQ    = 4'b1000;
    localparam logic [3:0] OP_NE    = 4'b1001;
    localparam logic [3:0] OP_LT    = 4'b1010;
    localparam logic [3:0] OP_GE    = 4'b1011;
    localparam logic [3:0] OP_LTU   = 4'b1100;
    localparam logic [3:0] OP_GEU   = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MDU  = 7'b0000001;

    function automatic logic [3:0] arith_op(input logic [2:0] f3);
        case (f3)
            3'b000:  arith_op = OP_ADD;
            3'b001:  arith_op = OP_SLL;
            3'b010:  arith_op = OP_LT;
            3'b011:  arith_op = OP_LTU;
            3'b100:  arith_op = OP_XOR;
            3'b101:  arith_op = OP_SRL;
            3'b110:  arith_op = OP_OR;
            default: arith_op = OP_AND;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output is defaulted first so no path through the case infers a latch.
        Operation = OP_ADD;
        illegal   = 1'b0;
        is_mdu    = 1'b0;
        case (ALUOp)
            2'b00: Operation = OP_ADD;
            2'b01: begin
                case (Funct3)
                    3'b000:  Operation = OP_EQ;
                    3'b001:  Operation = OP_NE;
                    3'b100:  Operation = OP_LT;
                    3'b101:  Operation = OP_GE;
                    3'b110:  Operation = OP_LTU;
                    3'b111:  Operation = OP_GEU;
                    default: illegal   = 1'b1;
                endcase
            end
            2'b10: begin
                if (Itype) begin
                    // Immediate forms: Funct7 is mostly immediate bits, shifts keep their checks.
                    if (Funct3 == 3'b101)
                        Operation = Funct7[5] ? OP_SRA : OP_SRL;
                    else if ((Funct3 == 3'b001 && Funct7 != F7_BASE) || Funct7 == F7_ALT)
                        illegal = 1'b1;
                    else
                        Operation = arith_op(Funct3);
                end else if (Funct7 == F7_BASE) begin
                    Operation = arith_op(Funct3);
                end else if (Funct7 == F7_ALT && Funct3 == 3'b000) begin
                    Operation = OP_SUB;
                end else if (Funct7 == F7_ALT && Funct3 == 3'b101) begin
                    Operation = OP_SRA;
                end else if (Funct7 == F7_MDU && MDU_EN) begin
                    is_mdu = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: Operation = OP_PASSB;
        endcase
        if (illegal) Operation = OP_ADD;
    end

    if (MDU_EN) begin : g_mdu
        localparam int CW = $clog2(XLEN);
        localparam logic [1:0] S_IDLE = 2'd0;
        localparam logic [1:0] S_MUL  = 2'd1;
        localparam logic [1:0] S_DIV  = 2'd2;
        localparam logic [1:0] S_DONE = 2'd3;

        logic [1:0]      state_q,    state_d;
        logic [CW-1:0]   cnt_q,      cnt_d;
        logic [2:0]      f3_q,       f3_d;
        logic [XLEN-1:0] a_q,        a_d;
        logic [XLEN-1:0] opnd_q,     opnd_d;
        logic [XLEN-1:0] lo_q,       lo_d;
        logic [XLEN-1:0] acc_q,      acc_d;
        logic            neg_main_q, neg_main_d;
        logic            neg_rem_q,  neg_rem_d;
        logic            bzero_q,    bzero_d;
        logic [XLEN-1:0] result_q,   result_d;

        logic            a_signed, b_signed, neg_a, neg_b, start, last_step, fits;
        logic [XLEN-1:0] mag_a, mag_b, acc_step, lo_step, quo, rem;
        logic [XLEN:0]   sum, shifted, trial;
        logic [2*XLEN-1:0] product, prod_s;

        always_comb begin
            a_signed = Funct3[2] ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
            b_signed = Funct3[2] ? ~Funct3[0] : ~Funct3[1];
            neg_a    = a_signed & src_a[XLEN-1];
            neg_b    = b_signed & src_b[XLEN-1];
            mag_a    = neg_a ? -src_a : src_a;
            mag_b    = neg_b ? -src_b : src_b;
            start    = (state_q == S_IDLE) && valid_i && is_mdu;

            // Multiply: shift-add over {acc, lo}; divide: restoring step over {acc, lo}.
            sum      = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
            shifted  = {acc_q, lo_q[XLEN-1]};
            trial    = shifted - {1'b0, opnd_q};
            fits     = ~trial[XLEN];
            if (state_q == S_DIV) begin
                acc_step = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
                lo_step  = {lo_q[XLEN-2:0], fits};
            end else begin
                acc_step = sum[XLEN:1];
                lo_step  = {sum[0], lo_q[XLEN-1:1]};
            end

            product = {acc_step, lo_step};
            prod_s  = neg_main_q ? -product : product;
            quo     = bzero_q ? '1  : (neg_main_q ? -lo_step  : lo_step);
            rem     = bzero_q ? a_q : (neg_rem_q  ? -acc_step : acc_step);
            last_step = (cnt_q == CW'(XLEN - 1));

            state_d    = state_q;
            cnt_d      = cnt_q;
            f3_d       = f3_q;
            a_d        = a_q;
            opnd_d     = opnd_q;
            lo_d       = lo_q;
            acc_d      = acc_q;
            neg_main_d = neg_main_q;
            neg_rem_d  = neg_rem_q;
            bzero_d    = bzero_q;
            result_d   = result_q;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = Funct3[2] ? S_DIV : S_MUL;
                        cnt_d      = '0;
                        f3_d       = Funct3;
                        a_d        = src_a;
                        opnd_d     = Funct3[2] ? mag_b : mag_a;
                        lo_d       = Funct3[2] ? mag_a : mag_b;
                        acc_d      = '0;
                        neg_main_d = neg_a ^ neg_b;
                        neg_rem_d  = neg_a;
                        bzero_d    = (src_b == '0);
                    end
                end
                S_MUL, S_DIV: begin
                    acc_d = acc_step;
                    lo_d  = lo_step;
                    cnt_d = cnt_q + 1'b1;
                    if (last_step) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                        if (state_q == S_DIV)
                            result_d = f3_q[1] ? rem : quo;
                        else
                            result_d = (f3_q[1:0] == 2'b00) ? prod_s[XLEN-1:0]
                                                            : prod_s[2*XLEN-1:XLEN];
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q    <= S_IDLE;
                cnt_q      <= '0;
                f3_q       <= '0;
                a_q        <= '0;
                opnd_q     <= '0;
                lo_q       <= '0;
                acc_q      <= '0;
                neg_main_q <= 1'b0;
                neg_rem_q  <= 1'b0;
                bzero_q    <= 1'b0;
                result_q   <= '0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                f3_q       <= f3_d;
                a_q        <= a_d;
                opnd_q     <= opnd_d;
                lo_q       <= lo_d;
                acc_q      <= acc_d;
                neg_main_q <= neg_main_d;
                neg_rem_q  <= neg_rem_d;
                bzero_q    <= bzero_d;
                result_q   <= result_d;
            end
        end

        assign stall      = start || (state_q == S_MUL) || (state_q == S_DIV);
        assign mdu_done   = (state_q == S_DONE);
        assign mdu_result = result_q;
    end else begin : g_no_mdu
        assign stall      = 1'b0;
        assign mdu_done   = 1'b0;
        assign mdu_result = '0;
    end

endmodule

// File: tb/tb_alu_mdu_controller.sv
// Self-checking bench: random decode against a table model, MDU results against wide arithmetic.
// A second instance with the M-extension disabled covers the no-MDU build.
module tb_alu_mdu_controller;

    localparam int XLEN = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_EQ    = 4'b1000;
    localparam logic [3:0] OP_NE    = 4'b1001;
    localparam logic [3:0] OP_LT    = 4'b1010;
    localparam logic [3:0] OP_GE    = 4'b1011;
    localparam logic [3:0] OP_LTU   = 4'b1100;
    localparam logic [3:0] OP_GEU   = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;
    localparam logic [3:0] NONE     = 4'b1111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, valid_i, valid0_i, Itype;
    logic [1:0]      ALUOp;
    logic [6:0]      Funct7;
    logic [2:0]      Funct3;
    logic [XLEN-1:0] src_a, src_b;
    logic [3:0]      op1, op0;
    logic            ill1, ill0, mdu1, mdu0, stall1, stall0, done1, done0;
    logic [XLEN-1:0] res1, res0;

    int n_cmp = 0;
    int n_err = 0;

    alu_mdu_controller #(.XLEN(XLEN), .MDU_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ALUOp(ALUOp), .Itype(Itype),
        .Funct7(Funct7), .Funct3(Funct3), .src_a(src_a), .src_b(src_b),
        .Operation(op1), .illegal(ill1), .is_mdu(mdu1), .stall(stall1),
        .mdu_done(done1), .mdu_result(res1)
    );

    alu_mdu_controller #(.XLEN(XLEN), .MDU_EN(1'b0)) dut_nomdu (
        .clk(clk), .reset(reset), .valid_i(valid0_i), .ALUOp(ALUOp), .Itype(Itype),
        .Funct7(Funct7), .Funct3(Funct3), .src_a(src_a), .src_b(src_b),
        .Operation(op0), .illegal(ill0), .is_mdu(mdu0), .stall(stall0),
        .mdu_done(done0), .mdu_result(res0)
    );

    // Decode reference: opcode tables indexed by Funct3, plus the encoding rules for ALUOp 10.
    function automatic void ref_decode(input logic [1:0] aluop, input logic itype,
                                       input logic [6:0] f7, input logic [2:0] f3,
                                       input bit mdu_en, output logic [3:0] op,
                                       output logic ill, output logic mdu);
        logic [3:0] rtab [8];
        logic [3:0] btab [8];
        rtab = '{OP_ADD, OP_SLL, OP_LT, OP_LTU, OP_XOR, OP_SRL, OP_OR, OP_AND};
        btab = '{OP_EQ, OP_NE, NONE, NONE, OP_LT, OP_GE, OP_LTU, OP_GEU};
        op = OP_ADD; ill = 1'b0; mdu = 1'b0;
        if (aluop == 2'b11) op = OP_PASSB;
        else if (aluop == 2'b01) begin
            if (btab[f3] == NONE) ill = 1'b1; else op = btab[f3];
        end else if (aluop == 2'b10) begin
            if (itype) begin
                if (f3 == 3'd5) op = f7[5] ? OP_SRA : OP_SRL;
                else if (f7 == 7'h20 || (f3 == 3'd1 && f7 != 7'h00)) ill = 1'b1;
                else op = rtab[f3];
            end else if (f7 == 7'h00) op = rtab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) op = OP_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) op = OP_SRA;
            else if (f7 == 7'h01 && mdu_en) mdu = 1'b1;
            else ill = 1'b1;
        end
        if (ill) op = OP_ADD;
    endfunction

    // MDU reference: 128-bit products and native signed/unsigned division with RISC-V corner rules.
    function automatic logic [31:0] mdu_ref(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [127:0] sa, sb, ua, ub, p;
        int ia, ib;
        sa = {{96{a[31]}}, a}; sb = {{96{b[31]}}, b};
        ua = {96'b0, a};       ub = {96'b0, b};
        ia = a;                ib = b;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF :
                         (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a :
                         (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 3))
            0:       return 7'h00;
            1:       return 7'h20;
            2:       return 7'h01;
            default: return 7'($urandom);
        endcase
    endfunction

    task automatic drive_mdu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1; ALUOp = 2'b10; Itype = 1'b0; Funct7 = 7'h01;
        Funct3 = f3; src_a = a; src_b = b;
    endtask

    // One MDU transaction, with a different MDU request held on the inputs while busy and in DONE.
    task automatic run_mdu(input string name, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        int bad;
        @(negedge clk);
        drive_mdu(f3, a, b);
        #1;
        n_cmp++;
        if (stall1 !== 1'b1) begin n_err++; $display("FAIL %s stall_at_T: got %b want 1", name, stall1); end
        @(posedge clk); #1;
        drive_mdu(3'($urandom_range(0, 7)), $urandom, $urandom);
        bad = 0;
        for (int i = 0; i < XLEN; i++) begin
            if (stall1 !== 1'b1 || done1 !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL %s busy_window: %0d bad cycles, want 0", name, bad); end
        n_cmp++;
        if (done1 !== 1'b1) begin n_err++; $display("FAIL %s done_pulse: got %b want 1", name, done1); end
        n_cmp++;
        if (stall1 !== 1'b0) begin n_err++; $display("FAIL %s stall_in_done: got %b want 0", name, stall1); end
        n_cmp++;
        if (res1 !== exp) begin n_err++; $display("FAIL %s result: got %h want %h", name, res1, exp); end
        valid_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (done1 !== 1'b0 || stall1 !== 1'b0) begin
            n_err++; $display("FAIL %s after_done: done=%b stall=%b want 0/0", name, done1, stall1);
        end
        n_cmp++;
        if (res1 !== exp) begin n_err++; $display("FAIL %s result_hold: got %h want %h", name, res1, exp); end
    endtask

    task automatic test_reset();
        reset = 1'b0; valid_i = 1'b0; valid0_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (stall1 !== 1'b0 || done1 !== 1'b0 || res1 !== '0) begin
            n_err++; $display("FAIL reset_state: stall=%b done=%b res=%h want 0/0/0", stall1, done1, res1);
        end
        n_cmp++;
        if (stall0 !== 1'b0 || done0 !== 1'b0 || res0 !== '0) begin
            n_err++; $display("FAIL reset_state_nomdu: stall=%b done=%b res=%h want 0/0/0", stall0, done0, res0);
        end
        ALUOp = 2'b11; #1;
        n_cmp++;
        if (op1 !== OP_PASSB) begin n_err++; $display("FAIL reset_comb_passb: got %b want %b", op1, OP_PASSB); end
        ALUOp = 2'b01; Funct3 = 3'b010; #1;
        n_cmp++;
        if (ill1 !== 1'b1) begin n_err++; $display("FAIL reset_comb_illegal: got %b want 1", ill1); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_decode_directed();
        ALUOp = 2'b10; Itype = 1'b0; Funct7 = 7'h20; Funct3 = 3'b000; #1;
        n_cmp++;
        if (op1 !== OP_SUB || ill1 !== 1'b0) begin
            n_err++; $display("FAIL dec_sub: op=%b ill=%b want %b/0", op1, ill1, OP_SUB);
        end
        Itype = 1'b1; #1;
        n_cmp++;
        if (op1 !== OP_ADD || ill1 !== 1'b1) begin
            n_err++; $display("FAIL dec_subi_illegal: op=%b ill=%b want %b/1", op1, ill1, OP_ADD);
        end
        Funct3 = 3'b101; Funct7 = 7'h20; #1;
        n_cmp++;
        if (op1 !== OP_SRA || ill1 !== 1'b0) begin
            n_err++; $display("FAIL dec_srai: op=%b ill=%b want %b/0", op1, ill1, OP_SRA);
        end
        Funct3 = 3'b001; Funct7 = 7'h04; #1;
        n_cmp++;
        if (ill1 !== 1'b1) begin n_err++; $display("FAIL dec_slli_bad_f7: ill=%b want 1", ill1); end
        Itype = 1'b0; Funct7 = 7'h01; Funct3 = 3'b100; #1;
        n_cmp++;
        if (mdu1 !== 1'b1 || ill1 !== 1'b0) begin
            n_err++; $display("FAIL dec_div_mdu: is_mdu=%b ill=%b want 1/0", mdu1, ill1);
        end
        n_cmp++;
        if (mdu0 !== 1'b0 || ill0 !== 1'b1 || op0 !== OP_ADD) begin
            n_err++; $display("FAIL dec_div_nomdu: is_mdu=%b ill=%b op=%b want 0/1/%b", mdu0, ill0, op0, OP_ADD);
        end
    endtask

    task automatic test_decode_random();
        logic [3:0] e_op;
        logic       e_ill, e_mdu;
        for (int i = 0; i < 300; i++) begin
            ALUOp = 2'($urandom); Itype = 1'($urandom); Funct7 = pick_f7(); Funct3 = 3'($urandom);
            #2;
            ref_decode(ALUOp, Itype, Funct7, Funct3, 1'b1, e_op, e_ill, e_mdu);
            n_cmp++;
            if (ill1 !== e_ill || mdu1 !== e_mdu || (!e_mdu && op1 !== e_op)) begin
                n_err++;
                $display("FAIL dec_rand a=%b i=%b f7=%h f3=%b: op=%b ill=%b mdu=%b want %b/%b/%b",
                         ALUOp, Itype, Funct7, Funct3, op1, ill1, mdu1, e_op, e_ill, e_mdu);
            end
            ref_decode(ALUOp, Itype, Funct7, Funct3, 1'b0, e_op, e_ill, e_mdu);
            n_cmp++;
            if (ill0 !== e_ill || mdu0 !== e_mdu || op0 !== e_op) begin
                n_err++;
                $display("FAIL dec_rand_nomdu a=%b i=%b f7=%h f3=%b: op=%b ill=%b mdu=%b want %b/%b/%b",
                         ALUOp, Itype, Funct7, Funct3, op0, ill0, mdu0, e_op, e_ill, e_mdu);
            end
        end
    endtask

    task automatic test_mdu_disabled();
        int bad;
        bad = 0;
        valid_i = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            valid0_i = 1'b1; ALUOp = 2'b10; Itype = 1'b0; Funct7 = 7'h01;
            Funct3 = 3'($urandom); src_a = $urandom; src_b = $urandom;
            #1;
            if (stall0 !== 1'b0 || done0 !== 1'b0 || ill0 !== 1'b1 || mdu0 !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        if (stall0 !== 1'b0 || done0 !== 1'b0) bad++;
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL nomdu_never_busy: %0d bad cycles, want 0", bad); end
        valid0_i = 1'b0;
    endtask

    task automatic test_mdu_directed();
        run_mdu("mulh_min_x2",  3'd1, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);
        run_mdu("div_m7_2",     3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        run_mdu("rem_m7_2",     3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        run_mdu("divu_7_0",     3'd5, 32'h00000007, 32'h00000000, 32'hFFFFFFFF);
        run_mdu("rem_7_0",      3'd6, 32'h00000007, 32'h00000000, 32'h00000007);
        run_mdu("div_overflow", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_mdu("rem_overflow", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_mdu("mulhsu_neg",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_mdu("mulhu_max",    3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    endtask

    task automatic test_mid_reset();
        run_mdu("mul_pre_reset", 3'd0, 32'd3, 32'd5, 32'd15);
        @(negedge clk);
        drive_mdu(3'd0, 32'd12345, 32'd6789);
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_cmp++;
        if (stall1 !== 1'b1) begin n_err++; $display("FAIL midreset_busy_T10: stall=%b want 1", stall1); end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (stall1 !== 1'b0 || done1 !== 1'b0 || res1 !== '0) begin
            n_err++; $display("FAIL midreset_cleared: stall=%b done=%b res=%h want 0/0/0", stall1, done1, res1);
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (stall1 !== 1'b0 || done1 !== 1'b0) begin
            n_err++; $display("FAIL midreset_discarded: stall=%b done=%b want 0/0", stall1, done1);
        end
        run_mdu("mul_after_reset", 3'd0, 32'd12345, 32'd6789, mdu_ref(3'd0, 32'd12345, 32'd6789));
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom);
            a  = pick_operand();
            b  = pick_operand();
            run_mdu($sformatf("rand%0d_f3=%0d_a=%h_b=%h", i, f3, a, b), f3, a, b, mdu_ref(f3, a, b));
        end
    endtask

    initial begin
        reset = 1'b0; valid_i = 1'b0; valid0_i = 1'b0; ALUOp = 2'b00; Itype = 1'b0;
        Funct7 = 7'h00; Funct3 = 3'b000; src_a = '0; src_b = '0;
        test_reset();
        test_decode_directed();
        test_decode_random();
        test_mdu_disabled();
        test_mdu_directed();
        test_mid_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
